ddr2_local_traffic_master: RTL and testbench
============================================

// Module: ddr2_local_traffic_master
// PURPOSE
//  Initiator on the controller local interface (the interface the DDR2 controller serves as responder).
//  On start it performs two passes over NUM_BURSTS bursts of BURST_LEN beats from base_addr:
//  - write pass: deterministic pattern;
//  - read-back pass: compares returned data.
//  Reports pass/fail, error count and first failing address. Used for board bring-up and regression soak.
// PARAMETERS
//  ADDR_W      24        local_address width (local-word units, 1 word = DATA_W bits)
//  DATA_W      128       local_wdata/local_rdata width (multiple of 32)
//  BE_W        16        local_be width (DATA_W/8)
//  SIZE_W      3         local_size width
//  BURST_LEN   2         beats per burst (1..2**SIZE_W-1)
//  MAX_OUTST   8         max read beats requested but not yet returned
// PORTS
//  clk                 in   1       controller phy clock; all logic on rising edge
//  reset               in   1       synchronous, active-high
//  start               in   1       1-cycle pulse; starts a test when idle
//  base_addr           in   ADDR_W  first word address; sampled on accepted start
//  num_bursts          in   16      bursts per pass (0 = finish immediately, pass=1)
//  seed                in   32      pattern seed; sampled on accepted start
//  local_init_done     in   1       controller calibrated/initialised
//  local_ready         in   1       controller accepts current request this cycle
//  local_rdata         in   DATA_W  read data beat
//  local_rdata_valid   in   1       local_rdata valid this cycle
//  local_address       out  ADDR_W  burst start address
//  local_burstbegin    out  1       first beat of a burst request
//  local_size          out  SIZE_W  BURST_LEN
//  local_write_req     out  1       write beat request
//  local_read_req      out  1       read burst request
//  local_wdata         out  DATA_W  write beat data
//  local_be            out  BE_W    all ones
//  busy                out  1       test in progress
//  done                out  1       test complete; held until next accepted start
//  pass                out  1       valid while done; 1 = zero errors
//  err_count           out  16      mismatching/unexpected beats, saturates at 16'hFFFF
//  first_err_addr      out  ADDR_W  word address of first mismatch; 0 if none
// BEHAVIOUR
//  - Reset values:
//    - all request outputs 0; local_address 0; local_wdata 0; local_size = BURST_LEN; local_be all ones.
//    - busy=0, done=0, pass=0, err_count=0, first_err_addr=0.
//  - Pattern: for word address A, 32-bit lane k = ({8'b0,A} + k) ^ seed, k = 0..DATA_W/32-1.
//  - FSM states: IDLE -> WAIT_INIT -> WRITE -> READ -> DRAIN -> DONE.
//    - IDLE: start accepted (also from DONE) -> clear counters/done, busy=1, go WAIT_INIT. start while busy is ignored.
//    - WAIT_INIT: proceed to WRITE when local_init_done=1.
//      - num_bursts=0: go straight to DONE with pass=1.
//    - WRITE, per burst:
//      - beat 0 drives write_req=1, burstbegin=1, address = burst base.
//      - Beats 1..BURST_LEN-1 drive write_req=1, burstbegin=0.
//      - A beat completes only in a cycle with local_ready=1. While ready=0, all outputs are held stable (address, data, burstbegin).
//      - Back-to-back bursts carry no idle cycle. Burst base advances by BURST_LEN, modulo 2**ADDR_W.
//      - After the last beat of the last burst -> READ (write_req=0 in that next cycle).
//    - READ:
//      - Drive read_req=1 with burstbegin=1 only if outstanding + BURST_LEN <= MAX_OUTST. The request is accepted when local_ready=1.
//      - Outstanding counter: +BURST_LEN on accept, -1 per rdata_valid. Both in the same cycle apply the net change.
//      - After the last burst is accepted -> DRAIN.
//    - DRAIN: wait until outstanding = 0 -> DONE.
//    - DONE: busy=0, done=1, pass = (err_count==0).
//  - Checker:
//    - The expected-address counter starts at base_addr and advances by 1 per rdata_valid, wrapping mod 2**ADDR_W.
//    - Compare in the same cycle. On a mismatch, err_count increments.
//    - first_err_addr is latched only on the first error.
//    - rdata_valid with outstanding=0 (including in IDLE/DONE): err_count += 1, nothing else changes.
//  - local_init_done dropping mid-test does not change state; requests simply stall on local_ready.
//  - Reset mid-operation: all requests drop in the reset cycle and state returns to IDLE.
//    - In-flight read data arriving after reset counts as unexpected only if the FSM is already busy again; otherwise it is ignored.
//    - Ignored data is not counted.
// STRUCTURE
//  - Shared package ddr2_tg_pkg: FSM state encoding and the pattern function pat_word(addr, seed). The checker uses the same function.
//  - One sub-module, ddr2_tg_checker: expected-address counter, compare, err_count saturation, first_err_addr latch.
// TESTING
//  - Basic:
//    - Stimulus: ready=1, base=0, num_bursts=4, BURST_LEN=2, ideal memory model.
//    - Response: 8 write beats at addr 0,2,4,6, then 4 reads; done with pass=1, err_count=0.
//  - Backpressure:
//    - Stimulus: random local_ready at 30% duty.
//    - Response: outputs stable across every ready=0 cycle; memory contents match the pattern; pass=1.
//  - Fault injection:
//    - Stimulus: model corrupts word 5 (bit 0).
//    - Response: err_count=1, first_err_addr=5, pass=0.
//  - Wrap and flow control:
//    - Stimulus: base=24'hFFFFFE, num_bursts=2, model rdata latency 20 cycles.
//    - Response: second burst at addr 0; outstanding never exceeds 8; pass=1.
//  - Boundaries:
//    - num_bursts=0 -> done and pass in at most 3 cycles with no requests.
//    - start while busy -> ignored.
//    - Stray rdata_valid in IDLE -> err_count=1.
//  - Reset mid-operation:
//    - Stimulus: reset asserted mid-WRITE.
//    - Response: next cycle write_req=0, busy=0; a new start runs to pass=1.

Source files
------------

// File: rtl/ddr2_tg_pkg.sv
// Shared definitions for the DDR2 local-interface traffic master: FSM encoding and data pattern.
package ddr2_tg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitInit,
    StWrite,
    StRead,
    StDrain,
    StDone
  } tg_state_e;

  // One 32-bit lane of the pattern for word address addr (zero-extended to 32 bits).
  function automatic logic [31:0] pat_word(input logic [31:0] addr, input logic [31:0] lane,
                                           input logic [31:0] seed);
    return (addr + lane) ^ seed;
  endfunction

endpackage

// File: rtl/ddr2_local_traffic_master_if.sv
// Controller local interface: the traffic master initiates, the DDR2 controller responds.
interface ddr2_local_traffic_master_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned BE_W   = 16,
  parameter int unsigned SIZE_W = 3
);
  logic              local_init_done;
  logic              local_ready;
  logic [DATA_W-1:0] local_rdata;
  logic              local_rdata_valid;
  logic [ADDR_W-1:0] local_address;
  logic              local_burstbegin;
  logic [SIZE_W-1:0] local_size;
  logic              local_write_req;
  logic              local_read_req;
  logic [DATA_W-1:0] local_wdata;
  logic [BE_W-1:0]   local_be;

  modport master (
    input  local_init_done, local_ready, local_rdata, local_rdata_valid,
    output local_address, local_burstbegin, local_size, local_write_req, local_read_req,
           local_wdata, local_be
  );

  modport slave (
    output local_init_done, local_ready, local_rdata, local_rdata_valid,
    input  local_address, local_burstbegin, local_size, local_write_req, local_read_req,
           local_wdata, local_be
  );
endinterface

// File: rtl/ddr2_tg_checker.sv
// Read-back checker: tracks the expected word address, compares returned beats against the
// pattern, counts errors (saturating) and latches the address of the first mismatch.
module ddr2_tg_checker
  import ddr2_tg_pkg::*;
#(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [31:0]       seed_i,
  input  logic              rvalid_i,
  input  logic              stray_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [15:0]       err_count_o,
  output logic [ADDR_W-1:0] first_err_addr_o
);

  logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              seen_q, seen_d;
  logic [DATA_W-1:0] exp_word;
  logic              mismatch;

  always_comb begin
    exp_word = '0;
    for (int k = 0; k < DATA_W / 32; k++) begin
      exp_word[k*32 +: 32] = pat_word(32'(exp_addr_q), 32'(k), seed_i);
    end
  end

  assign mismatch = rvalid_i && (rdata_i != exp_word);

  always_comb begin
    exp_addr_d = exp_addr_q;
    err_d      = err_q;
    first_d    = first_q;
    seen_d     = seen_q;
    if (clear_i) begin
      exp_addr_d = start_addr_i;
      err_d      = '0;
      first_d    = '0;
      seen_d     = 1'b0;
    end else begin
      if (rvalid_i) begin
        exp_addr_d = exp_addr_q + 1'b1;
      end
      if ((mismatch || stray_i) && (err_q != 16'hFFFF)) begin
        err_d = err_q + 16'd1;
      end
      // Stray beats carry no address, so only real mismatches set the first-error address.
      if (mismatch && !seen_q) begin
        first_d = exp_addr_q;
        seen_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      exp_addr_q <= '0;
      err_q      <= '0;
      first_q    <= '0;
      seen_q     <= 1'b0;
    end else begin
      exp_addr_q <= exp_addr_d;
      err_q      <= err_d;
      first_q    <= first_d;
      seen_q     <= seen_d;
    end
  end

  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;

endmodule

// File: rtl/ddr2_local_traffic_master.sv
// DDR2 local-interface traffic master: writes a seeded pattern over NUM_BURSTS bursts, reads it
// back with bounded outstanding reads, and reports pass/fail, error count and first bad address.
module ddr2_local_traffic_master
  import ddr2_tg_pkg::*;
#(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned BE_W      = 16,
  parameter int unsigned SIZE_W    = 3,
  parameter int unsigned BURST_LEN = 2,
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [15:0]       num_bursts_i,
  input  logic [31:0]       seed_i,
  ddr2_local_traffic_master_if.master local_io,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [15:0]       err_count_o,
  output logic [ADDR_W-1:0] first_err_addr_o
);

  localparam int unsigned OutW  = $clog2(MAX_OUTST + BURST_LEN + 1);
  localparam int unsigned BeatW = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_W-1:0] BurstStep = ADDR_W'(BURST_LEN);
  localparam logic [BeatW-1:0]  LastBeat  = BeatW'(BURST_LEN - 1);
  localparam logic [OutW-1:0]   OutLimit  = OutW'(MAX_OUTST - BURST_LEN);
  localparam logic [OutW-1:0]   OutStep   = OutW'(BURST_LEN);

  tg_state_e         state_q, state_d;
  logic [ADDR_W-1:0] burst_addr_q, burst_addr_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [15:0]       left_q, left_d;
  logic [OutW-1:0]   outst_q, outst_d;
  logic [OutW-1:0]   orphan_q, orphan_d;
  logic [ADDR_W-1:0] start_addr_q;
  logic [31:0]       seed_q;
  logic [15:0]       nbursts_q;

  logic              start_ok, busy, rd_accept, rd_expected, stray, clear;
  logic              write_req, read_req, burstbegin;
  logic [ADDR_W-1:0] address;
  logic [ADDR_W-1:0] wr_word_addr;
  logic [DATA_W-1:0] wr_pat;
  logic [15:0]       err_count;

  assign busy     = (state_q != StIdle) && (state_q != StDone);
  assign start_ok = start_i && !busy;
  assign clear    = start_ok;

  assign wr_word_addr = burst_addr_q + ADDR_W'(beat_q);

  always_comb begin
    wr_pat = '0;
    for (int k = 0; k < DATA_W / 32; k++) begin
      wr_pat[k*32 +: 32] = pat_word(32'(wr_word_addr), 32'(k), seed_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    burst_addr_d = burst_addr_q;
    beat_d       = beat_q;
    left_d       = left_q;
    write_req    = 1'b0;
    read_req     = 1'b0;
    burstbegin   = 1'b0;
    address      = '0;
    rd_accept    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) state_d = StWaitInit;
      end
      StWaitInit: begin
        if (nbursts_q == 16'd0) begin
          state_d = StDone;
        end else if (local_io.local_init_done) begin
          state_d      = StWrite;
          burst_addr_d = start_addr_q;
          beat_d       = '0;
          left_d       = nbursts_q;
        end
      end
      StWrite: begin
        write_req  = 1'b1;
        burstbegin = (beat_q == '0);
        address    = burst_addr_q;
        if (local_io.local_ready) begin
          if (beat_q == LastBeat) begin
            beat_d = '0;
            if (left_q == 16'd1) begin
              state_d      = StRead;
              burst_addr_d = start_addr_q;
              left_d       = nbursts_q;
            end else begin
              burst_addr_d = burst_addr_q + BurstStep;
              left_d       = left_q - 16'd1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StRead: begin
        // Only request when the whole burst fits in the outstanding budget.
        if (outst_q <= OutLimit) begin
          read_req   = 1'b1;
          burstbegin = 1'b1;
          address    = burst_addr_q;
          if (local_io.local_ready) begin
            rd_accept    = 1'b1;
            burst_addr_d = burst_addr_q + BurstStep;
            left_d       = left_q - 16'd1;
            if (left_q == 16'd1) state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (outst_q == '0) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // Beats still owed from before a reset are dropped silently until the next start.
  always_comb begin
    rd_expected = local_io.local_rdata_valid && (outst_q != '0);
    stray       = local_io.local_rdata_valid && (outst_q == '0) && (busy || (orphan_q == '0));
    outst_d     = outst_q + (rd_accept ? OutStep : '0) - OutW'(rd_expected);
    orphan_d    = orphan_q;
    if (start_ok) begin
      orphan_d = '0;
    end else if (local_io.local_rdata_valid && (outst_q == '0) && !busy && (orphan_q != '0)) begin
      orphan_d = orphan_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      burst_addr_q <= '0;
      beat_q       <= '0;
      left_q       <= '0;
      outst_q      <= '0;
      start_addr_q <= '0;
      seed_q       <= '0;
      nbursts_q    <= '0;
      // Remember reads in flight when reset hits mid-test; a held reset forgets them.
      orphan_q     <= busy ? outst_q : '0;
    end else begin
      state_q      <= state_d;
      burst_addr_q <= burst_addr_d;
      beat_q       <= beat_d;
      left_q       <= left_d;
      outst_q      <= outst_d;
      orphan_q     <= orphan_d;
      if (start_ok) begin
        start_addr_q <= base_addr_i;
        seed_q       <= seed_i;
        nbursts_q    <= num_bursts_i;
      end
    end
  end

  ddr2_tg_checker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_checker (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .clear_i         (clear),
    .start_addr_i    (base_addr_i),
    .seed_i          (seed_q),
    .rvalid_i        (rd_expected),
    .stray_i         (stray),
    .rdata_i         (local_io.local_rdata),
    .err_count_o     (err_count),
    .first_err_addr_o(first_err_addr_o)
  );

  assign local_io.local_address    = address;
  assign local_io.local_burstbegin = burstbegin;
  assign local_io.local_size       = SIZE_W'(BURST_LEN);
  assign local_io.local_write_req  = write_req;
  assign local_io.local_read_req   = read_req;
  assign local_io.local_wdata      = write_req ? wr_pat : '0;
  assign local_io.local_be         = '1;

  assign busy_o      = busy;
  assign done_o      = (state_q == StDone);
  assign pass_o      = (state_q == StDone) && (err_count == 16'd0);
  assign err_count_o = err_count;

endmodule

// File: tb/tb_ddr2_local_traffic_master.sv
// Self-checking bench: memory model with latency and backpressure, write/read scoreboards.
module tb_ddr2_local_traffic_master;

  localparam int BL = 2;
  localparam int MO = 8;

  typedef struct {
    logic [23:0] addr;
    int          due;
  } rd_t;

  typedef struct {
    logic [23:0] beat;
    logic [23:0] base;
    bit          first;
  } wexp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] base_addr;
  logic [15:0] num_bursts;
  logic [31:0] seed;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [23:0] first_err_addr;

  ddr2_local_traffic_master_if bus ();

  ddr2_local_traffic_master dut (
    .clk_i           (clk),
    .reset_i         (rst),
    .start_i         (start),
    .base_addr_i     (base_addr),
    .num_bursts_i    (num_bursts),
    .seed_i          (seed),
    .local_io        (bus.master),
    .busy_o          (busy),
    .done_o          (done),
    .pass_o          (pass),
    .err_count_o     (err_count),
    .first_err_addr_o(first_err_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [127:0] mem [logic [23:0]];
  rd_t          rq[$];
  wexp_t        wq[$];
  logic [23:0]  rdq[$];

  int          ready_pct, lat;
  bit          corrupt_en, stray_pend;
  logic [23:0] corrupt_addr;
  logic [31:0] tb_seed;
  int          wr_seen, wr_bad, rd_seen, rd_bad, stab_bad, req_seen, max_outst;
  int          req_beats, ret_beats, first_wr_cyc, last_wr_cyc;
  logic [23:0] wcur;
  int          widx;
  bit          stall_prev;
  logic [154:0] snap;

  function automatic logic [127:0] tb_pat(input logic [23:0] a, input logic [31:0] s);
    logic [127:0] w;
    for (int k = 0; k < 4; k++) w[k*32 +: 32] = ({8'b0, a} + 32'(k)) ^ s;
    return w;
  endfunction

  task automatic reset_model();
    rq.delete(); wq.delete(); rdq.delete(); mem.delete();
    wr_seen = 0; wr_bad = 0; rd_seen = 0; rd_bad = 0; stab_bad = 0; req_seen = 0;
    max_outst = 0; req_beats = 0; ret_beats = 0; first_wr_cyc = -1; last_wr_cyc = -1;
    stall_prev = 0; corrupt_en = 0; stray_pend = 0; widx = 0; wcur = '0;
  endtask

  // One clock: drive responder inputs just after the edge, observe requests on the falling edge.
  task automatic step();
    logic [155:0] cur;
    logic [23:0]  a;
    int           outs;
    @(posedge clk);
    #1;
    cyc++;
    bus.local_ready = ($urandom_range(0, 99) < ready_pct);
    if (stray_pend) begin
      bus.local_rdata_valid = 1'b1;
      bus.local_rdata       = {4{$urandom}};
      stray_pend            = 0;
    end else if (rq.size() > 0 && rq[0].due <= cyc) begin
      a = rq[0].addr;
      void'(rq.pop_front());
      bus.local_rdata       = mem.exists(a) ? mem[a] : '0;
      if (corrupt_en && a == corrupt_addr) bus.local_rdata[0] = ~bus.local_rdata[0];
      bus.local_rdata_valid = 1'b1;
      ret_beats++;
    end else begin
      bus.local_rdata_valid = 1'b0;
    end
    @(negedge clk);
    cur = {1'b0, bus.local_write_req, bus.local_read_req, bus.local_burstbegin,
           bus.local_address, bus.local_wdata};
    if (stall_prev && cur[154:0] != snap) stab_bad++;
    stall_prev = (bus.local_write_req || bus.local_read_req) && !bus.local_ready;
    snap = cur[154:0];
    if (bus.local_write_req || bus.local_read_req) req_seen++;
    if (bus.local_write_req && bus.local_ready) begin
      if (bus.local_burstbegin) begin
        wcur = bus.local_address;
        widx = 0;
      end else begin
        widx++;
      end
      a = wcur + 24'(widx);
      mem[a] = bus.local_wdata;
      wr_seen++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      if (wq.size() == 0) begin
        wr_bad++;
      end else begin
        if (wq[0].beat !== a || wq[0].base !== bus.local_address ||
            wq[0].first !== bus.local_burstbegin || bus.local_wdata !== tb_pat(wq[0].beat, tb_seed))
          wr_bad++;
        void'(wq.pop_front());
      end
    end
    if (bus.local_read_req && bus.local_ready) begin
      rd_seen++;
      if (rdq.size() == 0 || rdq[0] !== bus.local_address || bus.local_burstbegin !== 1'b1)
        rd_bad++;
      if (rdq.size() > 0) void'(rdq.pop_front());
      for (int b = 0; b < BL; b++) rq.push_back('{addr: bus.local_address + 24'(b), due: cyc + lat});
      req_beats += BL;
    end
    outs = req_beats - ret_beats;
    if (outs > max_outst) max_outst = outs;
  endtask

  task automatic launch(input logic [23:0] b, input logic [15:0] nb, input logic [31:0] s);
    base_addr  = b;
    num_bursts = nb;
    seed       = s;
    tb_seed    = s;
    for (int i = 0; i < int'(nb); i++) begin
      for (int j = 0; j < BL; j++)
        wq.push_back('{beat: b + 24'(i * BL + j), base: b + 24'(i * BL), first: (j == 0)});
      rdq.push_back(b + 24'(i * BL));
    end
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout done=%b required=1 after %0d cycles", tag, done, n);
    end
  endtask

  task automatic check_run(input string tag, input logic exp_pass, input logic [15:0] exp_err,
                           input logic [23:0] exp_first);
    checks++;
    if (pass !== exp_pass) begin
      errors++; $display("FAIL %s_pass got=%b want=%b", tag, pass, exp_pass);
    end
    checks++;
    if (err_count !== exp_err) begin
      errors++; $display("FAIL %s_err_count got=%0d want=%0d", tag, err_count, exp_err);
    end
    checks++;
    if (first_err_addr !== exp_first) begin
      errors++; $display("FAIL %s_first_err got=%h want=%h", tag, first_err_addr, exp_first);
    end
    checks++;
    if (wr_bad !== 0 || rd_bad !== 0 || wq.size() !== 0 || rdq.size() !== 0) begin
      errors++;
      $display("FAIL %s_scoreboard wr_bad=%0d rd_bad=%0d left_w=%0d left_r=%0d want all 0",
               tag, wr_bad, rd_bad, wq.size(), rdq.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s_busy got=%b want=0", tag, busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.local_write_req !== 1'b0 || bus.local_read_req !== 1'b0 ||
        bus.local_burstbegin !== 1'b0 || bus.local_address !== 24'h0 ||
        bus.local_wdata !== 128'h0) begin
      errors++;
      $display("FAIL reset_requests wr=%b rd=%b bb=%b addr=%h wdata=%h want all 0",
               bus.local_write_req, bus.local_read_req, bus.local_burstbegin,
               bus.local_address, bus.local_wdata);
    end
    checks++;
    if (bus.local_size !== 3'd2 || bus.local_be !== 16'hFFFF) begin
      errors++;
      $display("FAIL reset_size_be size=%0d be=%h want 2/ffff", bus.local_size, bus.local_be);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_count !== 16'd0 ||
        first_err_addr !== 24'd0) begin
      errors++;
      $display("FAIL reset_status busy=%b done=%b pass=%b err=%0d first=%h want 0",
               busy, done, pass, err_count, first_err_addr);
    end
  endtask

  task automatic test_basic();
    reset_model();
    ready_pct = 100; lat = 2;
    launch(24'h0, 16'd4, 32'h1234_5678);
    run_to_done(200, "basic");
    check_run("basic", 1'b1, 16'd0, 24'd0);
    checks++;
    if (wr_seen !== 8 || rd_seen !== 4) begin
      errors++; $display("FAIL basic_counts wr=%0d rd=%0d want 8/4", wr_seen, rd_seen);
    end
    checks++;
    if (last_wr_cyc - first_wr_cyc + 1 !== 8) begin
      errors++;
      $display("FAIL basic_write_span got=%0d want=8", last_wr_cyc - first_wr_cyc + 1);
    end
  endtask

  task automatic test_backpressure();
    int mem_bad = 0;
    logic [23:0] a;
    reset_model();
    ready_pct = 30; lat = 3;
    launch(24'h001000, 16'd6, 32'hCAFE_F00D);
    run_to_done(2000, "bp");
    check_run("bp", 1'b1, 16'd0, 24'd0);
    checks++;
    if (stab_bad !== 0) begin
      errors++; $display("FAIL bp_stable_on_stall got=%0d want=0", stab_bad);
    end
    for (int i = 0; i < 12; i++) begin
      a = 24'h001000 + 24'(i);
      if (!mem.exists(a) || mem[a] !== tb_pat(a, 32'hCAFE_F00D)) mem_bad++;
    end
    checks++;
    if (mem_bad !== 0) begin
      errors++; $display("FAIL bp_memory_pattern bad_words=%0d want=0", mem_bad);
    end
  endtask

  task automatic test_fault();
    reset_model();
    ready_pct = 100; lat = 2;
    corrupt_en = 1; corrupt_addr = 24'd5;
    launch(24'h0, 16'd4, 32'h0BAD_BEEF);
    run_to_done(200, "fault");
    check_run("fault", 1'b0, 16'd1, 24'd5);
  endtask

  task automatic test_wrap();
    reset_model();
    ready_pct = 100; lat = 20;
    launch(24'hFFFFFE, 16'd2, 32'h5555_AAAA);
    run_to_done(300, "wrap");
    check_run("wrap", 1'b1, 16'd0, 24'd0);
    checks++;
    if (max_outst > MO) begin
      errors++; $display("FAIL wrap_outstanding got=%0d want<=%0d", max_outst, MO);
    end
  endtask

  task automatic test_flow_control();
    reset_model();
    ready_pct = 100; lat = 20;
    launch(24'h000200, 16'd8, 32'h0F0F_0F0F);
    run_to_done(500, "flow");
    check_run("flow", 1'b1, 16'd0, 24'd0);
    checks++;
    if (max_outst !== MO) begin
      errors++; $display("FAIL flow_max_outstanding got=%0d want=%0d", max_outst, MO);
    end
  endtask

  task automatic test_boundaries();
    int n;
    reset_model();
    ready_pct = 100; lat = 2;
    launch(24'h000040, 16'd0, 32'h0);
    n = 1;
    while (done !== 1'b1 && n < 3) begin
      step();
      n++;
    end
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || req_seen !== 0) begin
      errors++;
      $display("FAIL zero_bursts done=%b pass=%b reqs=%0d cycles=%0d want 1/1/0 within 3",
               done, pass, req_seen, n);
    end
    // Start while busy must not restart or retarget the test.
    reset_model();
    launch(24'h000040, 16'd4, 32'h7777_1111);
    step(); step(); step();
    base_addr = 24'h000900;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL busy_start_status busy=%b done=%b want 1/0", busy, done);
    end
    run_to_done(200, "busy_start");
    check_run("busy_start", 1'b1, 16'd0, 24'd0);
    // Stray read data in IDLE counts as an error.
    rst = 1'b1; step(); step(); rst = 1'b0;
    reset_model();
    step();
    stray_pend = 1;
    step(); step(); step();
    checks++;
    if (err_count !== 16'd1 || busy !== 1'b0 || done !== 1'b0 || first_err_addr !== 24'd0) begin
      errors++;
      $display("FAIL stray_idle err=%0d busy=%b done=%b first=%h want 1/0/0/0",
               err_count, busy, done, first_err_addr);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    reset_model();
    ready_pct = 100; lat = 2;
    launch(24'h000100, 16'd8, 32'h2468_ACE0);
    while (wr_seen < 3 && n < 50) begin
      step();
      n++;
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus.local_write_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_drop write_req=%b busy=%b want 0/0", bus.local_write_req, busy);
    end
    rst = 1'b0;
    reset_model();
    step();
    launch(24'h000100, 16'd8, 32'h2468_ACE0);
    run_to_done(300, "reset_mid");
    check_run("reset_mid", 1'b1, 16'd0, 24'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_bursts = '0; seed = '0;
    bus.local_init_done   = 1'b1;
    bus.local_ready       = 1'b0;
    bus.local_rdata       = '0;
    bus.local_rdata_valid = 1'b0;
    ready_pct = 100; lat = 2; tb_seed = '0; corrupt_addr = '0; snap = '0;
    reset_model();
    step(); step(); step();
    rst = 1'b0;
    step();
    test_reset();
    test_basic();
    test_backpressure();
    test_fault();
    test_wrap();
    test_flow_control();
    test_boundaries();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
